down_arb: RTL and testbench

DOWN_ARB -- requirements
Module: down_arb

---
 rtl/um_pkt_pkg.sv | 27 ++
 rtl/um_pkt_fifo.sv | 46 ++++
 rtl/down_arb.sv | 220 ++++++++++++++++++++++
 tb/tb_down_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/um_pkt_pkg.sv
// Shared packet-site encodings, FIFO geometry, backpressure thresholds and
// arbiter state type for the down-port merge block.
package um_pkt_pkg;
  localparam int PKT_W = 134;

  localparam logic [1:0] SITE_HEAD = 2'b01;
  localparam logic [1:0] SITE_BODY = 2'b11;
  localparam logic [1:0] SITE_TAIL = 2'b10;

  localparam int DFIFO_DEPTH = 256;
  localparam int VFIFO_DEPTH = 64;
  localparam int DFIFO_ALF   = 192;
  localparam int VFIFO_ALF   = 56;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DROP} arb_state_t;

  typedef struct packed {
    logic [1:0]   site;
    logic [3:0]   inv;
    logic [127:0] payload;
  } pkt_word_t;

  // A zero weight still earns one packet per turn.
  function automatic logic [3:0] eff_weight(input logic [3:0] w);
    return (w == 4'd0) ? 4'd1 : w;
  endfunction
endpackage

// File: rtl/um_pkt_fifo.sv
// Show-ahead FIFO with occupancy count; q always presents the oldest word.
// Writes into a full FIFO are silently discarded.
module um_pkt_fifo #(
  parameter int WIDTH = 134,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         q,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   usedw
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             wr_en, rd_en;

  assign empty = (usedw == '0);
  assign wr_en = wr && (usedw != FULL_CNT);
  assign rd_en = rd && !empty;
  assign q     = mem[rp];

  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      usedw <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   usedw <= usedw + 1'b1;
        2'b01:   usedw <= usedw - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/down_arb.sv
// Two-source weighted round-robin packet merge onto one down port.
// Define DOWN_ARB_STAT_EN to add packet/drop/overflow statistics outputs.
module down_arb
  import um_pkt_pkg::*;
#(
  parameter logic [3:0] W0 = 4'd4,
  parameter logic [3:0] W1 = 4'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s0_data_wr,
  input  logic [PKT_W-1:0] s0_data,
  input  logic             s0_valid_wr,
  input  logic             s0_valid,
  output logic             s0_alf,
  input  logic             s1_data_wr,
  input  logic [PKT_W-1:0] s1_data,
  input  logic             s1_valid_wr,
  input  logic             s1_valid,
  output logic             s1_alf,
  output logic             out_data_wr,
  output logic [PKT_W-1:0] out_data,
  output logic             out_valid_wr,
  output logic             out_valid,
`ifdef DOWN_ARB_STAT_EN
  output logic [31:0]      stat_pkt0,
  output logic [31:0]      stat_pkt1,
  output logic [31:0]      stat_drop,
  output logic [15:0]      stat_ovf,
`endif
  input  logic             down_alf
);
  localparam logic [3:0] WE0 = eff_weight(W0);
  localparam logic [3:0] WE1 = eff_weight(W1);
  localparam logic [8:0] D_ALF = 9'(DFIFO_ALF);
  localparam logic [6:0] V_ALF = 7'(VFIFO_ALF);

  logic [1:0]            d_wr, d_rd, d_empty, v_wr, v_rd, v_empty, v_din, v_q;
  logic [1:0][PKT_W-1:0] d_din, d_q;
  logic [1:0][8:0]       d_usedw;
  logic [1:0][6:0]       v_usedw;

  assign d_wr  = {s1_data_wr, s0_data_wr};
  assign d_din = {s1_data, s0_data};
  assign v_wr  = {s1_valid_wr, s0_valid_wr};
  assign v_din = {s1_valid, s0_valid};

  for (genvar i = 0; i < 2; i++) begin : g_src
    um_pkt_fifo #(.WIDTH(PKT_W), .DEPTH(DFIFO_DEPTH)) u_dfifo (
      .clk(clk), .reset(reset), .wr(d_wr[i]), .din(d_din[i]), .rd(d_rd[i]),
      .q(d_q[i]), .empty(d_empty[i]), .usedw(d_usedw[i]));
    um_pkt_fifo #(.WIDTH(1), .DEPTH(VFIFO_DEPTH)) u_vfifo (
      .clk(clk), .reset(reset), .wr(v_wr[i]), .din(v_din[i]), .rd(v_rd[i]),
      .q(v_q[i]), .empty(v_empty[i]), .usedw(v_usedw[i]));
  end

  arb_state_t       state, state_n;
  logic             sel, sel_n, ptr, ptr_n;
  logic [3:0]       cred, cred_n;
  logic             hold_vld, hold_vld_n, hold_sel, hold_sel_n, hold_ptr, hold_ptr_n;
  logic [3:0]       hold_cred, hold_cred_n;
  logic [1:0]       elig;
  logic             g_vld, g_sel, g_ptr;
  logic [3:0]       g_cred;
  logic             word_rd, cur_tail;
  logic             owr_n, ovwr_n;
  logic [PKT_W-1:0] odata_n;

  function automatic logic [3:0] weight(input logic s);
    return s ? WE1 : WE0;
  endfunction

  // Grant candidate; a stalled SEND decision is replayed verbatim from hold_*.
  always_comb begin
    elig   = ~v_empty;
    g_vld  = 1'b0;
    g_sel  = ptr;
    g_ptr  = ptr;
    g_cred = cred;
    if (elig[ptr] && cred != 4'd0) begin
      g_vld  = 1'b1;
      g_cred = cred - 4'd1;
    end else if (elig[~ptr]) begin
      g_vld  = 1'b1;
      g_sel  = ~ptr;
      g_ptr  = ~ptr;
      g_cred = weight(~ptr) - 4'd1;
    end else if (elig[ptr]) begin
      g_vld  = 1'b1;
      g_cred = weight(ptr) - 4'd1;
    end
    if (hold_vld) begin
      g_vld  = 1'b1;
      g_sel  = hold_sel;
      g_ptr  = hold_ptr;
      g_cred = hold_cred;
    end
  end

  assign word_rd  = !d_empty[sel];
  assign cur_tail = (d_q[sel][133:132] == SITE_TAIL);

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    ptr_n       = ptr;
    cred_n      = cred;
    hold_vld_n  = hold_vld;
    hold_sel_n  = hold_sel;
    hold_ptr_n  = hold_ptr;
    hold_cred_n = hold_cred;
    d_rd        = '0;
    v_rd        = '0;
    owr_n       = 1'b0;
    ovwr_n      = 1'b0;
    odata_n     = out_data;
    case (state)
      ST_IDLE: if (g_vld) begin
        if (!v_q[g_sel]) begin
          // Discards bypass backpressure and leave the rotation untouched.
          state_n    = ST_DROP;
          sel_n      = g_sel;
          hold_vld_n = 1'b0;
        end else if (!down_alf) begin
          state_n    = ST_SEND;
          sel_n      = g_sel;
          ptr_n      = g_ptr;
          cred_n     = g_cred;
          hold_vld_n = 1'b0;
        end else begin
          hold_vld_n  = 1'b1;
          hold_sel_n  = g_sel;
          hold_ptr_n  = g_ptr;
          hold_cred_n = g_cred;
        end
      end
      ST_SEND: if (word_rd) begin
        d_rd[sel] = 1'b1;
        owr_n     = 1'b1;
        odata_n   = d_q[sel];
        if (cur_tail) begin
          ovwr_n    = 1'b1;
          v_rd[sel] = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_DROP: if (word_rd) begin
        d_rd[sel] = 1'b1;
        if (cur_tail) begin
          v_rd[sel] = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sel          <= 1'b0;
      ptr          <= 1'b0;
      cred         <= WE0;
      hold_vld     <= 1'b0;
      hold_sel     <= 1'b0;
      hold_ptr     <= 1'b0;
      hold_cred    <= '0;
      out_data_wr  <= 1'b0;
      out_data     <= '0;
      out_valid_wr <= 1'b0;
      out_valid    <= 1'b0;
      s0_alf       <= 1'b0;
      s1_alf       <= 1'b0;
    end else begin
      state        <= state_n;
      sel          <= sel_n;
      ptr          <= ptr_n;
      cred         <= cred_n;
      hold_vld     <= hold_vld_n;
      hold_sel     <= hold_sel_n;
      hold_ptr     <= hold_ptr_n;
      hold_cred    <= hold_cred_n;
      out_data_wr  <= owr_n;
      out_data     <= odata_n;
      out_valid_wr <= ovwr_n;
      out_valid    <= ovwr_n;
      s0_alf       <= (d_usedw[0] >= D_ALF) || (v_usedw[0] >= V_ALF);
      s1_alf       <= (d_usedw[1] >= D_ALF) || (v_usedw[1] >= V_ALF);
    end
  end

`ifdef DOWN_ARB_STAT_EN
  localparam logic [8:0] D_FULL = 9'(DFIFO_DEPTH);
  localparam logic [6:0] V_FULL = 7'(VFIFO_DEPTH);
  logic [3:0]  ovf_bits;
  logic [2:0]  ovf_cnt;
  logic [16:0] ovf_sum;

  assign ovf_bits = {d_wr[1] && (d_usedw[1] == D_FULL), d_wr[0] && (d_usedw[0] == D_FULL),
                     v_wr[1] && (v_usedw[1] == V_FULL), v_wr[0] && (v_usedw[0] == V_FULL)};
  assign ovf_cnt  = 3'($countones(ovf_bits));
  assign ovf_sum  = {1'b0, stat_ovf} + {14'd0, ovf_cnt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_pkt0 <= '0;
      stat_pkt1 <= '0;
      stat_drop <= '0;
      stat_ovf  <= '0;
    end else begin
      if (state == ST_SEND && word_rd && cur_tail) begin
        if (sel) stat_pkt1 <= stat_pkt1 + 32'd1;
        else     stat_pkt0 <= stat_pkt0 + 32'd1;
      end
      if (state == ST_DROP && word_rd && cur_tail) stat_drop <= stat_drop + 32'd1;
      stat_ovf <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_down_arb.sv
// Directed bench for down_arb: reset, weighted round-robin order, discard,
// backpressure hold/release, almost-full/overflow, and mid-packet reset.
module tb_down_arb;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         s0_data_wr = 0, s1_data_wr = 0, s0_valid_wr = 0, s1_valid_wr = 0;
  logic         s0_valid = 0, s1_valid = 0, down_alf = 0;
  logic [133:0] s0_data = '0, s1_data = '0;
  logic         s0_alf, s1_alf, out_data_wr, out_valid_wr, out_valid;
  logic [133:0] out_data;
`ifdef DOWN_ARB_STAT_EN
  logic [31:0]  stat_pkt0, stat_pkt1, stat_drop;
  logic [15:0]  stat_ovf;
`endif

  int pass_cnt = 0, total_cnt = 0, cyc = 0;
  logic [133:0] log_word[$];
  int           log_wcyc[$];
  int           log_psrc[$];
  int           log_ptag[$];
  int           log_pcyc[$];

  down_arb dut (
    .clk(clk), .reset(reset),
    .s0_data_wr(s0_data_wr), .s0_data(s0_data), .s0_valid_wr(s0_valid_wr),
    .s0_valid(s0_valid), .s0_alf(s0_alf),
    .s1_data_wr(s1_data_wr), .s1_data(s1_data), .s1_valid_wr(s1_valid_wr),
    .s1_valid(s1_valid), .s1_alf(s1_alf),
    .out_data_wr(out_data_wr), .out_data(out_data), .out_valid_wr(out_valid_wr),
    .out_valid(out_valid),
`ifdef DOWN_ARB_STAT_EN
    .stat_pkt0(stat_pkt0), .stat_pkt1(stat_pkt1), .stat_drop(stat_drop), .stat_ovf(stat_ovf),
`endif
    .down_alf(down_alf));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_data_wr) begin
      log_word.push_back(out_data);
      log_wcyc.push_back(cyc);
    end
    if (out_valid_wr && out_valid) begin
      log_psrc.push_back(int'(out_data[127:120]));
      log_ptag.push_back(int'(out_data[119:112]));
      log_pcyc.push_back(cyc);
    end
  end

  function automatic logic [133:0] mk(input int src, input int tag, input int idx, input int n);
    logic [1:0] site;
    site = (idx == 0) ? 2'b01 : (idx == n - 1) ? 2'b10 : 2'b11;
    return {site, 4'h0, 8'(src), 8'(tag), 8'(idx), 104'h0};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_pkt(input int src, input int tag, input int n, input bit vld);
    for (int i = 0; i < n; i++) begin
      if (src == 0) begin
        s0_data_wr = 1; s0_data = mk(src, tag, i, n);
        s0_valid_wr = (i == n - 1); s0_valid = vld;
      end else begin
        s1_data_wr = 1; s1_data = mk(src, tag, i, n);
        s1_valid_wr = (i == n - 1); s1_valid = vld;
      end
      tick();
    end
    s0_data_wr = 0; s0_valid_wr = 0; s1_data_wr = 0; s1_valid_wr = 0;
  endtask

  task automatic do_reset();
    s0_data_wr = 0; s1_data_wr = 0; s0_valid_wr = 0; s1_valid_wr = 0; down_alf = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    log_word.delete(); log_wcyc.delete(); log_psrc.delete(); log_ptag.delete(); log_pcyc.delete();
  endtask

  task automatic wait_pkts(input int n, input int budget, input string name);
    int k = 0;
    while (log_psrc.size() < n && k < budget) begin tick(); k++; end
    total_cnt++;
    if (log_psrc.size() < n) $display("FAIL %s timeout: got %0d packets, need %0d", name, log_psrc.size(), n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (out_data_wr !== 1'b0) $display("FAIL rst_out_data_wr got %b want 0", out_data_wr); else pass_cnt++;
    total_cnt++; if (out_valid_wr !== 1'b0) $display("FAIL rst_out_valid_wr got %b want 0", out_valid_wr); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 134'd0) $display("FAIL rst_out_data got %h want 0", out_data); else pass_cnt++;
    total_cnt++; if ({s1_alf, s0_alf} !== 2'b00) $display("FAIL rst_alf got %b want 00", {s1_alf, s0_alf}); else pass_cnt++;
`ifdef DOWN_ARB_STAT_EN
    total_cnt++; if ({stat_pkt0, stat_pkt1, stat_drop} !== 96'd0 || stat_ovf !== 16'd0)
      $display("FAIL rst_stats got %0d/%0d/%0d/%0d want 0", stat_pkt0, stat_pkt1, stat_drop, stat_ovf); else pass_cnt++;
`endif
  endtask

  task automatic test_round_robin();
    int exp_src[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int t0 = 0, t1 = 0, et;
    do_reset();
    down_alf = 1;
    for (int i = 0; i < 8; i++) push_pkt(0, i, 3, 1);
    for (int i = 0; i < 2; i++) push_pkt(1, i, 3, 1);
    repeat (3) tick();
    total_cnt++; if (log_word.size() != 0) $display("FAIL rr_hold got %0d words want 0", log_word.size()); else pass_cnt++;
    down_alf = 0;
    wait_pkts(10, 200, "rr");
    for (int i = 0; i < 10 && i < log_psrc.size(); i++) begin
      et = (exp_src[i] == 0) ? t0 : t1;
      if (exp_src[i] == 0) t0++; else t1++;
      total_cnt++;
      if (log_psrc[i] !== exp_src[i] || log_ptag[i] !== et)
        $display("FAIL rr_pkt%0d got src%0d tag%0d want src%0d tag%0d", i, log_psrc[i], log_ptag[i], exp_src[i], et);
      else pass_cnt++;
    end
    total_cnt++; if (log_word.size() != 30) $display("FAIL rr_words got %0d want 30", log_word.size()); else pass_cnt++;
    if (log_pcyc.size() >= 10) begin
      total_cnt++; if (log_pcyc[9] - log_pcyc[0] != 36)
        $display("FAIL rr_span got %0d cycles want 36", log_pcyc[9] - log_pcyc[0]); else pass_cnt++;
    end
  endtask

  task automatic test_src1_only();
    int c0;
    do_reset();
    down_alf = 1;
    for (int i = 0; i < 3; i++) push_pkt(1, 20 + i, 3, 1);
    down_alf = 0;
    c0 = cyc;
    wait_pkts(3, 100, "s1only");
    for (int i = 0; i < 3 && i < log_psrc.size(); i++) begin
      total_cnt++; if (log_psrc[i] !== 1 || log_ptag[i] !== 20 + i)
        $display("FAIL s1_pkt%0d got src%0d tag%0d want src1 tag%0d", i, log_psrc[i], log_ptag[i], 20 + i); else pass_cnt++;
    end
    if (log_pcyc.size() >= 3) begin
      total_cnt++; if (log_pcyc[0] - c0 != 4) $display("FAIL s1_first_tail got %0d want 4", log_pcyc[0] - c0); else pass_cnt++;
      total_cnt++; if (log_pcyc[1] - log_pcyc[0] != 4) $display("FAIL s1_gap1 got %0d want 4", log_pcyc[1] - log_pcyc[0]); else pass_cnt++;
      total_cnt++; if (log_pcyc[2] - log_pcyc[1] != 4) $display("FAIL s1_gap2 got %0d want 4", log_pcyc[2] - log_pcyc[1]); else pass_cnt++;
    end
  endtask

  task automatic test_drop();
    do_reset();
    push_pkt(0, 30, 3, 0);
    push_pkt(0, 31, 3, 1);
    wait_pkts(1, 50, "drop");
    repeat (4) tick();
    total_cnt++; if (log_word.size() != 3) $display("FAIL drop_words got %0d want 3", log_word.size()); else pass_cnt++;
    if (log_word.size() >= 1) begin
      total_cnt++; if (log_word[0] !== mk(0, 31, 0, 3)) $display("FAIL drop_head got %h want %h", log_word[0], mk(0, 31, 0, 3)); else pass_cnt++;
    end
    total_cnt++; if (log_psrc.size() != 1) $display("FAIL drop_pkts got %0d want 1", log_psrc.size()); else pass_cnt++;
`ifdef DOWN_ARB_STAT_EN
    total_cnt++; if (stat_drop !== 32'd1) $display("FAIL drop_stat got %0d want 1", stat_drop); else pass_cnt++;
    total_cnt++; if (stat_pkt0 !== 32'd1) $display("FAIL drop_pkt0 got %0d want 1", stat_pkt0); else pass_cnt++;
`endif
  endtask

  task automatic test_backpressure();
    int c0, k;
    do_reset();
    down_alf = 1;
    push_pkt(0, 40, 3, 1);
    repeat (5) tick();
    total_cnt++; if (log_word.size() != 0) $display("FAIL bp_hold got %0d words want 0", log_word.size()); else pass_cnt++;
    down_alf = 0;
    c0 = cyc;
    wait_pkts(1, 20, "bp_release");
    if (log_wcyc.size() >= 1) begin
      total_cnt++; if (log_wcyc[0] - c0 != 2) $display("FAIL bp_head_lat got %0d want 2", log_wcyc[0] - c0); else pass_cnt++;
    end
    push_pkt(0, 41, 5, 1);
    k = 0;
    while (log_word.size() < 4 && k < 20) begin tick(); k++; end
    down_alf = 1;
    wait_pkts(2, 20, "bp_midpkt");
    total_cnt++; if (log_word.size() != 8) $display("FAIL bp_mid_words got %0d want 8", log_word.size()); else pass_cnt++;
    if (log_word.size() >= 8) begin
      total_cnt++; if (log_word[7] !== mk(0, 41, 4, 5)) $display("FAIL bp_mid_tail got %h want %h", log_word[7], mk(0, 41, 4, 5)); else pass_cnt++;
    end
    down_alf = 0;
  endtask

  task automatic test_alf_ovf();
    do_reset();
    down_alf = 1;
    s0_data = mk(0, 50, 1, 3);
    s0_data_wr = 1;
    repeat (191) tick();
    s0_data_wr = 0;
    tick();
    total_cnt++; if (s0_alf !== 1'b0) $display("FAIL alf_191 got %b want 0", s0_alf); else pass_cnt++;
    s0_data_wr = 1; tick(); s0_data_wr = 0; tick();
    total_cnt++; if (s0_alf !== 1'b1) $display("FAIL alf_192 got %b want 1", s0_alf); else pass_cnt++;
    total_cnt++; if (s1_alf !== 1'b0) $display("FAIL alf_s1 got %b want 0", s1_alf); else pass_cnt++;
    s0_data_wr = 1;
    repeat (65) tick();
    s0_data_wr = 0;
`ifdef DOWN_ARB_STAT_EN
    total_cnt++; if (stat_ovf !== 16'd1) $display("FAIL ovf_cnt got %0d want 1", stat_ovf); else pass_cnt++;
`endif
    total_cnt++; if (log_word.size() != 0) $display("FAIL alf_no_out got %0d want 0", log_word.size()); else pass_cnt++;
    down_alf = 0;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_reset();
    push_pkt(0, 60, 5, 1);
    while (log_word.size() < 2 && k < 40) begin @(negedge clk); #1; k++; end
    reset = 1;
    #1;
    total_cnt++; if ({out_data_wr, out_valid_wr, out_valid} !== 3'b000 || out_data !== 134'd0)
      $display("FAIL rmid_outs got %b%b%b %h want 000 0", out_data_wr, out_valid_wr, out_valid, out_data); else pass_cnt++;
    tick(); tick();
    reset = 0;
    repeat (10) tick();
    total_cnt++; if (log_word.size() != 2) $display("FAIL rmid_words got %0d want 2", log_word.size()); else pass_cnt++;
    total_cnt++; if (log_psrc.size() != 0) $display("FAIL rmid_valid got %0d want 0", log_psrc.size()); else pass_cnt++;
    push_pkt(1, 61, 3, 1);
    wait_pkts(1, 30, "rmid_after");
    total_cnt++; if (log_word.size() != 5) $display("FAIL rmid_after_words got %0d want 5", log_word.size()); else pass_cnt++;
    if (log_word.size() >= 3) begin
      total_cnt++; if (log_word[2] !== mk(1, 61, 0, 3)) $display("FAIL rmid_head got %h want %h", log_word[2], mk(1, 61, 0, 3)); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_src1_only();
    test_drop();
    test_backpressure();
    test_alf_ovf();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
